// File: rtl/i2c_wr_seq_if.sv
// Signal bundle between the single-byte I2C write controller and its
// requester / pad wrapper: request fields, status flags and open-drain enables.
interface i2c_wr_seq_if;
   logic       start;
   logic [6:0] addr;
   logic [7:0] wdata;
   logic       sda_in;
   logic       scl_oe;
   logic       sda_oe;
   logic       busy;
   logic       done;
   logic       ack_err;

   // Controller side: takes the request and the resolved SDA level, drives enables/status.
   modport master (
      input  start, addr, wdata, sda_in,
      output scl_oe, sda_oe, busy, done, ack_err
   );

   // Requester / pad side.
   modport slave (
      output start, addr, wdata, sda_in,
      input  scl_oe, sda_oe, busy, done, ack_err
   );
endinterface

// File: rtl/i2c_wr_seq.sv
// Single-byte I2C write sequencer on the 100 MHz clock. A quarter-bit tick
// counter walks each bus slot through four quarters; the pad enables are
// registered and only move on tick edges or on the accept edge.
module i2c_wr_seq #(
   parameter int DIV = 250
) (
   input  logic         clk_100,
   input  logic         rst_n,
   i2c_wr_seq_if.master bus
);

   localparam int                CNT_W   = $clog2(DIV);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ZRO = CNT_W'(0);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_ADDR  = 3'd2,
      ST_ACK1  = 3'd3,
      ST_DATA  = 3'd4,
      ST_ACK2  = 3'd5,
      ST_STOP  = 3'd6
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       qtr_q, qtr_d;
   logic [2:0]       bit_q, bit_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       abyte_q, abyte_d;
   logic [7:0]       dbyte_q, dbyte_d;
   logic             scl_oe_q, scl_oe_d;
   logic             sda_oe_q, sda_oe_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             ack_err_q, ack_err_d;
   logic             tick_s;
   logic             accept_s;
   logic             cur_bit_s;

   // Slot sequencing: accept, quarter tick counting, bit walking, ACK sampling.
   always_comb begin
      state_d   = state_q;
      qtr_d     = qtr_q;
      bit_d     = bit_q;
      cnt_d     = cnt_q;
      abyte_d   = abyte_q;
      dbyte_d   = dbyte_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      ack_err_d = ack_err_q;
      tick_s    = 1'b0;
      accept_s  = 1'b0;

      if (state_q == ST_IDLE) begin
         cnt_d = CNT_ZRO;
         if (bus.start) begin
            accept_s  = 1'b1;
            abyte_d   = {bus.addr, 1'b0};
            dbyte_d   = bus.wdata;
            ack_err_d = 1'b0;
            busy_d    = 1'b1;
            state_d   = ST_START;
            qtr_d     = 2'd0;
            bit_d     = 3'd7;
         end else begin
            accept_s = 1'b0;
         end
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + CNT_ONE;
      end else begin
         tick_s = 1'b1;
         cnt_d  = CNT_ZRO;
         // The slave's answer is taken on the tick that ends Q2 (SCL high).
         if (((state_q == ST_ACK1) || (state_q == ST_ACK2)) && (qtr_q == 2'd2) && bus.sda_in) begin
            ack_err_d = 1'b1;
         end else begin
            ack_err_d = ack_err_d;
         end
         if (qtr_q != 2'd3) begin
            qtr_d = qtr_q + 2'd1;
         end else begin
            qtr_d = 2'd0;
            case (state_q)
               ST_START: begin
                  state_d = ST_ADDR;
                  bit_d   = 3'd7;
               end
               ST_ADDR: begin
                  if (bit_q == 3'd0) begin
                     state_d = ST_ACK1;
                  end else begin
                     bit_d = bit_q - 3'd1;
                  end
               end
               ST_ACK1: begin
                  // An address NACK skips the data byte entirely.
                  if (ack_err_q) begin
                     state_d = ST_STOP;
                  end else begin
                     state_d = ST_DATA;
                     bit_d   = 3'd7;
                  end
               end
               ST_DATA: begin
                  if (bit_q == 3'd0) begin
                     state_d = ST_ACK2;
                  end else begin
                     bit_d = bit_q - 3'd1;
                  end
               end
               ST_ACK2: begin
                  state_d = ST_STOP;
               end
               ST_STOP: begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
               end
               default: begin
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
               end
            endcase
         end
      end
   end

   // Pad enables for the quarter being entered; held between position changes.
   always_comb begin
      scl_oe_d  = scl_oe_q;
      sda_oe_d  = sda_oe_q;
      cur_bit_s = (state_d == ST_ADDR) ? abyte_d[bit_d] : dbyte_d[bit_d];
      if (tick_s || accept_s) begin
         case (state_d)
            ST_START: begin
               case (qtr_d)
                  2'd0:    begin scl_oe_d = 1'b0; sda_oe_d = 1'b0; end
                  2'd1:    begin scl_oe_d = 1'b0; sda_oe_d = 1'b1; end
                  default: begin scl_oe_d = 1'b1; sda_oe_d = 1'b1; end
               endcase
            end
            ST_ADDR, ST_DATA: begin
               case (qtr_d)
                  2'd0:    begin scl_oe_d = 1'b1; end
                  2'd1:    begin scl_oe_d = 1'b1; sda_oe_d = ~cur_bit_s; end
                  default: begin scl_oe_d = 1'b0; end
               endcase
            end
            ST_ACK1, ST_ACK2: begin
               case (qtr_d)
                  2'd0:    begin scl_oe_d = 1'b1; end
                  2'd1:    begin scl_oe_d = 1'b1; sda_oe_d = 1'b0; end
                  default: begin scl_oe_d = 1'b0; end
               endcase
            end
            ST_STOP: begin
               case (qtr_d)
                  2'd0:    begin scl_oe_d = 1'b1; end
                  2'd1:    begin scl_oe_d = 1'b1; sda_oe_d = 1'b1; end
                  2'd2:    begin scl_oe_d = 1'b0; sda_oe_d = 1'b1; end
                  default: begin scl_oe_d = 1'b0; sda_oe_d = 1'b0; end
               endcase
            end
            default: begin
               scl_oe_d = 1'b0;
               sda_oe_d = 1'b0;
            end
         endcase
      end else begin
         scl_oe_d = scl_oe_q;
         sda_oe_d = sda_oe_q;
      end
   end

   // State and output registers; reset releases the bus immediately.
   always_ff @(posedge clk_100 or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         qtr_q     <= 2'd0;
         bit_q     <= 3'd7;
         cnt_q     <= CNT_ZRO;
         abyte_q   <= 8'd0;
         dbyte_q   <= 8'd0;
         scl_oe_q  <= 1'b0;
         sda_oe_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ack_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         qtr_q     <= qtr_d;
         bit_q     <= bit_d;
         cnt_q     <= cnt_d;
         abyte_q   <= abyte_d;
         dbyte_q   <= dbyte_d;
         scl_oe_q  <= scl_oe_d;
         sda_oe_q  <= sda_oe_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         ack_err_q <= ack_err_d;
      end
   end

   assign bus.scl_oe  = scl_oe_q;
   assign bus.sda_oe  = sda_oe_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.ack_err = ack_err_q;

endmodule

// File: tb/tb_i2c_wr_seq.sv
// Bench for i2c_wr_seq: stimulus pushes expected transaction results into a
// scoreboard queue; a bus monitor with an I2C slave model decodes the lines,
// checks protocol rules and compares every completed transaction.
module tb_i2c_wr_seq;
   localparam int DIV      = 4;
   localparam int FULL_LAT = 80 * DIV;

   typedef struct {
      int         e0;
      logic       na;
      logic       nd;
      logic [7:0] b0;
      logic [7:0] b1;
      int         nbytes;
      int         ackv;
      int         err;
      int         err_off;
      int         lat;
   } exp_t;

   logic clk_100 = 1'b0;
   logic rst_n   = 1'b0;
   logic slave_pull = 1'b0;
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   exp_t sb_q[$];

   i2c_wr_seq_if bus ();
   i2c_wr_seq #(.DIV(DIV)) dut (.clk_100(clk_100), .rst_n(rst_n), .bus(bus));

   assign bus.sda_in = ~(bus.sda_oe | slave_pull);

   always #5 clk_100 = ~clk_100;
   always @(posedge clk_100) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: START (4 quarters) + 9 slots of 4 quarters per byte sent + STOP (4).
   function automatic exp_t model(input logic [6:0] a, input logic [7:0] d,
                                  input logic na, input logic nd, input int e0);
      exp_t e;
      e.e0      = e0;
      e.na      = na;
      e.nd      = nd;
      e.b0      = {a, 1'b0};
      e.b1      = d;
      e.nbytes  = na ? 1 : 2;
      e.ackv    = na ? 1 : (nd ? 2 : 0);
      e.err     = (na || nd) ? 1 : 0;
      e.lat     = DIV * (4 + 36 * e.nbytes + 4);
      e.err_off = na ? DIV * (4 + 32 + 3) : (nd ? DIV * (4 + 36 + 32 + 3) : -1);
      return e;
   endfunction

   // ---------------- monitor / slave model ----------------
   logic       prev_scl_oe, prev_sda_oe, prev_sda_line, prev_ack_err;
   logic       active, stop_seen, sda_line;
   logic [7:0] sh;
   logic [7:0] rx[$];
   int         acks[$];
   int         bitcnt, err_off, busy_cnt, ackv;
   exp_t       e;

   // Decode the bus every falling clock edge and score completed transactions.
   always @(negedge clk_100) begin
      if (!rst_n) begin
         slave_pull = 1'b0;
         active = 1'b0; stop_seen = 1'b0; bitcnt = 0; sh = 8'd0;
         rx.delete(); acks.delete();
         err_off = -1; busy_cnt = 0;
         prev_scl_oe = bus.scl_oe; prev_sda_oe = bus.sda_oe;
         prev_sda_line = ~bus.sda_oe; prev_ack_err = bus.ack_err;
      end else begin
         sda_line = bus.sda_in;
         if ((bus.scl_oe != prev_scl_oe) || (bus.sda_oe != prev_sda_oe))
            chk("oe_single_change", int'((bus.scl_oe != prev_scl_oe) && (bus.sda_oe != prev_sda_oe)), 0);
         // SDA moving while SCL is high: only START (fall) or STOP (rise) at legal points.
         if ((sda_line != prev_sda_line) && !bus.scl_oe && !prev_scl_oe) begin
            if (!sda_line) begin
               chk("start_only_when_bus_free", int'(active), 0);
               active = 1'b1; bitcnt = 0; stop_seen = 1'b0;
               rx.delete(); acks.delete();
            end else begin
               chk("stop_at_byte_boundary", int'(active && (bitcnt == 1)), 1);
               active = 1'b0; stop_seen = 1'b1; bitcnt = 0;
            end
         end
         if (prev_scl_oe && !bus.scl_oe && active) begin
            if (bitcnt < 8) sh = {sh[6:0], sda_line};
            else acks.push_back(int'(sda_line));
            bitcnt++;
         end
         if (!prev_scl_oe && bus.scl_oe && active) begin
            if (bitcnt == 8) begin
               if (sb_q.size() > 0)
                  slave_pull = (rx.size() == 0) ? ~sb_q[0].na : ~sb_q[0].nd;
               else
                  slave_pull = 1'b0;
            end else if (bitcnt == 9) begin
               slave_pull = 1'b0;
               rx.push_back(sh);
               bitcnt = 0;
            end
         end
         if (bus.busy) busy_cnt++;
         if (bus.ack_err && !prev_ack_err && (sb_q.size() > 0)) err_off = cyc - sb_q[0].e0;
         if (bus.done) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               e = sb_q.pop_front();
               ackv = 0;
               foreach (acks[i]) ackv = ackv | (acks[i] << i);
               chk("done_latency", cyc - e.e0, e.lat);
               chk("ack_err", int'(bus.ack_err), e.err);
               chk("ack_err_rise_cycle", err_off, e.err_off);
               chk("bytes_on_bus", rx.size(), e.nbytes);
               if (rx.size() > 0) chk("addr_byte", int'(rx[0]), int'(e.b0));
               if (rx.size() > 1) chk("data_byte", int'(rx[1]), int'(e.b1));
               chk("ack_bits", ackv, e.ackv);
               chk("stop_seen", int'(stop_seen), 1);
               chk("busy_cycles", busy_cnt, e.lat);
               chk("busy_low_at_done", int'(bus.busy), 0);
            end
            rx.delete(); acks.delete();
            stop_seen = 1'b0; err_off = -1; busy_cnt = 0;
         end
         prev_scl_oe   = bus.scl_oe;
         prev_sda_oe   = bus.sda_oe;
         prev_sda_line = ~(bus.sda_oe | slave_pull);
         prev_ack_err  = bus.ack_err;
      end
   end

   // ---------------- stimulus ----------------
   // Called at a falling edge with the controller idle; accept is the next rising edge.
   task automatic issue(input logic [6:0] a, input logic [7:0] d, input logic na, input logic nd);
      bus.start = 1'b1;
      bus.addr  = a;
      bus.wdata = d;
      @(posedge clk_100);
      #1;
      chk("accept_busy", int'(bus.busy), 1);
      chk("accept_ack_err_clear", int'(bus.ack_err), 0);
      sb_q.push_back(model(a, d, na, nd, cyc));
      @(negedge clk_100);
      bus.start = 1'b0;
      bus.addr  = 7'($urandom);
      bus.wdata = 8'($urandom);
   endtask

   // Returns at the falling edge inside the done cycle, or flags a timeout.
   task automatic wait_done();
      int n = 0;
      while ((bus.done !== 1'b1) && (n < 2 * FULL_LAT)) begin
         @(negedge clk_100);
         n++;
      end
      chk("done_within_budget", int'(bus.done === 1'b1), 1);
   endtask

   initial begin
      bus.start = 1'b0;
      bus.addr  = 7'd0;
      bus.wdata = 8'd0;
      #1;
      chk("rst_scl_oe", int'(bus.scl_oe), 0);
      chk("rst_sda_oe", int'(bus.sda_oe), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_ack_err", int'(bus.ack_err), 0);
      repeat (3) @(negedge clk_100);
      rst_n = 1'b1;
      repeat (2) @(negedge clk_100);
      chk("idle_busy", int'(bus.busy), 0);

      // Basic write, address NACK, data NACK.
      issue(7'h50, 8'hA5, 1'b0, 1'b0); wait_done();
      repeat (2) @(negedge clk_100);
      issue(7'h13, 8'h6E, 1'b1, 1'b0); wait_done();
      repeat (2) @(negedge clk_100);
      issue(7'h7F, 8'h00, 1'b0, 1'b1); wait_done();

      // Start while busy must not disturb the running transfer.
      repeat (2) @(negedge clk_100);
      issue(7'h50, 8'hA5, 1'b0, 1'b0);
      repeat (49) @(negedge clk_100);
      bus.start = 1'b1; bus.addr = 7'h2A; bus.wdata = 8'h3C;
      @(negedge clk_100);
      bus.start = 1'b0;
      wait_done();

      // Back-to-back: start raised in the done cycle.
      issue(7'h01, 8'hFF, 1'b0, 1'b0); wait_done();
      issue(7'h40, 8'h81, 1'b1, 1'b0); wait_done();
      issue(7'h22, 8'h5A, 1'b0, 1'b1); wait_done();

      // Reset in the middle of the address byte.
      repeat (2) @(negedge clk_100);
      issue(7'h55, 8'hC3, 1'b0, 1'b0);
      repeat (130) @(posedge clk_100);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_scl_oe", int'(bus.scl_oe), 0);
      chk("midrst_sda_oe", int'(bus.sda_oe), 0);
      chk("midrst_busy", int'(bus.busy), 0);
      sb_q.delete();
      repeat (3) @(negedge clk_100);
      rst_n = 1'b1;
      @(negedge clk_100);
      issue(7'h50, 8'hA5, 1'b0, 1'b0); wait_done();

      // Randomized transactions with random gaps (zero gap = back-to-back).
      for (int t = 0; t < 20; t++) begin
         logic na, nd;
         na = ($urandom_range(3, 0) == 0);
         nd = ($urandom_range(3, 0) == 0);
         repeat ($urandom_range(3, 0)) @(negedge clk_100);
         issue(7'($urandom), 8'($urandom), na, nd);
         wait_done();
      end

      repeat (4) @(negedge clk_100);
      chk("scoreboard_drained", sb_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #20000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
